instruction_queue: RTL and testbench

// - Parametrised instruction register with a small FIFO between program memory and decoder.
// - Buffers fetched words with valid/ready handshakes, supports pipeline flush, and inserts a
//   NOP bubble (default encoding CLEAR CARRY) when is_void is asserted.
// - Presents the full instruction word and an opcode/operand slice to the decode stage.

---
 rtl/isa_pkg.sv | 11 +
 rtl/ins_fifo_core.sv | 60 ++++++
 rtl/instruction_queue.sv | 71 +++++++
 tb/tb_instruction_queue.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants so the fetch queue and the decoder agree on word layout.
// NOP_WORD encodes CLEAR CARRY (bit 15) and is issued as the pipeline bubble.
package isa_pkg;

    localparam int INS_W = 22;
    localparam int OP_LSB = 8;
    localparam int OP_W = 14;
    localparam int IQ_DEPTH = 4;
    localparam logic [INS_W-1:0] NOP_WORD = 22'h008000;

endpackage

// File: rtl/ins_fifo_core.sv
// Plain circular buffer: storage, read/write pointers and occupancy count.
// Knows nothing about bubbles; the caller gates push/pop and drives clear.
module ins_fifo_core #(
    parameter int W     = 22,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  storage_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Entry storage; deliberately not reset, empty masking hides stale words.
    always_ff @(posedge clk) begin
        if (push) begin
            storage_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = storage_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});

endmodule

// File: rtl/instruction_queue.sv
// Fetch-to-decode instruction queue with valid/ready handshakes, flush and
// NOP bubble insertion; the head word is presented combinationally.
module instruction_queue
    import isa_pkg::*;
#(
    parameter int                INS_W_P  = INS_W,
    parameter int                OP_LSB_P = OP_LSB,
    parameter int                OP_W_P   = OP_W,
    parameter int                DEPTH    = IQ_DEPTH,
    parameter logic [INS_W_P-1:0] NOP_W_P = NOP_WORD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INS_W_P-1:0]       in_ins,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     is_void,
    output logic [INS_W_P-1:0]       out_ins_completa,
    output logic [OP_W_P-1:0]        out_ins,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                empty_s;
    logic [INS_W_P-1:0]  head_s;

    // A flush cycle discards any transfer that would otherwise happen.
    assign push_s = in_valid && !full_s && !flush;
    assign pop_s  = !empty_s && out_ready && !is_void && !flush;

    ins_fifo_core #(
        .W     (INS_W_P),
        .DEPTH (DEPTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (in_ins),
        .rd_data (head_s),
        .count   (count),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Bubble overrides the head and is itself an executable instruction.
    always_comb begin
        out_ins_completa = NOP_W_P;
        out_valid        = 1'b0;
        if (is_void) begin
            out_ins_completa = NOP_W_P;
            out_valid        = 1'b1;
        end else if (empty_s) begin
            out_ins_completa = NOP_W_P;
            out_valid        = 1'b0;
        end else begin
            out_ins_completa = head_s;
            out_valid        = 1'b1;
        end
    end

    assign out_ins  = out_ins_completa[OP_LSB_P +: OP_W_P];
    assign in_ready = !full_s;

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench: directed scenarios then random traffic, compared each
// cycle against a queue-based model of the fetch buffer.
module tb_instruction_queue;

    localparam logic [21:0] NOP = 22'h008000;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, is_void, out_ready;
    logic [21:0] in_ins;
    logic        in_ready, out_valid;
    logic [21:0] out_ins_completa;
    logic [13:0] out_ins;
    logic [2:0]  count;

    int n_assert = 0;
    int n_fail   = 0;
    logic [21:0] q[$];

    always #5 clk = ~clk;

    instruction_queue dut (
        .clk              (clk),
        .reset            (reset),
        .in_ins           (in_ins),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .flush            (flush),
        .is_void          (is_void),
        .out_ins_completa (out_ins_completa),
        .out_ins          (out_ins),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .count            (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        logic [21:0] ew;
        logic        ev;
        ev = is_void ? 1'b1 : (q.size() > 0);
        ew = (is_void || q.size() == 0) ? NOP : q[0];
        chk({tag, ".word"},  32'(out_ins_completa), 32'(ew));
        chk({tag, ".op"},    32'(out_ins),          32'(ew >> 8));
        chk({tag, ".valid"}, 32'(out_valid),        32'(ev));
        chk({tag, ".ready"}, 32'(in_ready),         32'(q.size() < 4));
        chk({tag, ".count"}, 32'(count),            32'(q.size()));
    endtask

    // Apply the model's rules for the inputs currently driven, then clock and check.
    task automatic tick(input string tag);
        bit do_push, do_pop;
        do_push = in_valid && (q.size() < 4);
        do_pop  = (q.size() > 0) && out_ready && !is_void;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(in_ins);
        end
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; is_void = 1'b0;
        out_ready = 1'b0; in_ins = 22'h0;
        tick("reset");
        reset = 1'b0;
        tick("idle");
        chk("idle.nop", 32'(out_ins_completa), 32'h008000);
        chk("idle.op",  32'(out_ins),          32'h0080);

        // Two pushes, then drain in order.
        in_valid = 1'b1; in_ins = 22'h3ABCDE; tick("push1");
        chk("push1.head", 32'(out_ins_completa), 32'h3ABCDE);
        in_ins = 22'h012345; tick("push2");
        in_valid = 1'b0; out_ready = 1'b1;
        tick("pop1");
        chk("pop1.head", 32'(out_ins_completa), 32'h012345);
        tick("pop2");
        out_ready = 1'b0;

        // Fill, overflow attempt, pop+push at full.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_ins = 22'(22'h100 + i); tick("fill");
        end
        in_ins = 22'h2AAAAA; tick("overflow");
        chk("overflow.count", 32'(count), 32'd4);
        out_ready = 1'b1; in_ins = 22'h055555; tick("fullpoppush");
        chk("fullpoppush.count", 32'(count), 32'd3);
        tick("pushafter");
        in_valid = 1'b0;
        while (q.size() > 0) tick("drain");
        in_valid = 1'b1; out_ready = 1'b0; in_ins = 22'h0A0A0A; tick("prime");
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_ins = 22'(22'h200 + i); tick("wrap");
        end
        in_valid = 1'b0;
        while (q.size() > 0) tick("drain2");

        // Bubble insertion holds the head.
        in_valid = 1'b1; out_ready = 1'b0; in_ins = 22'h1FFFFF; tick("voidpush");
        in_valid = 1'b0; out_ready = 1'b1; is_void = 1'b1; tick("void");
        chk("void.word",  32'(out_ins_completa), 32'h008000);
        chk("void.count", 32'(count),            32'd1);
        is_void = 1'b0; out_ready = 1'b0; #1;
        check_now("unvoid");
        chk("unvoid.word", 32'(out_ins_completa), 32'h1FFFFF);

        // Flush with concurrent push and pop.
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_ins = 22'(22'h300 + i); tick("preflush");
        end
        out_ready = 1'b1; flush = 1'b1; in_ins = 22'h3FFFFF; tick("flush");
        chk("flush.count", 32'(count), 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Reset mid-operation with a push pending.
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_ins = 22'(22'h400 + i); tick("prereset");
        end
        reset = 1'b1; in_ins = 22'h123456; tick("midreset");
        chk("midreset.count", 32'(count), 32'd0);
        reset = 1'b0; in_valid = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 99) < 60);
            out_ready = 1'($urandom_range(0, 99) < 50);
            is_void   = 1'($urandom_range(0, 99) < 10);
            flush     = 1'($urandom_range(0, 99) < 4);
            reset     = 1'($urandom_range(0, 99) < 1);
            in_ins    = 22'($urandom());
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
